simple_dp_ram: RTL and testbench

Simple dual-port synchronous RAM with one write-only port (A) and one read-only port (B) sharing a single clock. It is a generic storage primitive for buffers and lookup tables elsewhere in the design. Port A writes one word per cycle. Port B returns one word per cycle with one-cycle registered read latency.

---
 rtl/simple_dp_ram.sv | 63 ++++++
 tb/tb_simple_dp_ram.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: port A write-only, port B read-only, one clock. SDP_RAM_INIT_EN preloads word i = ~i.
// Latency: write visible to a read on the next edge; read data registered, valid one cycle after addrb.
// Backpressure: none; one write and one read accepted every cycle, read-first on same-address collision.
module simple_dp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wea,
    input  logic [ADDR-1:0]  addra,
    input  logic [WIDTH-1:0] dina,
    input  logic             enb,
    input  logic [ADDR-1:0]  addrb,
    output logic [WIDTH-1:0] doutb
);

    localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);

    typedef logic [DEPTH-1:0][WIDTH-1:0] mem_t;

`ifdef SDP_RAM_INIT_EN
    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = WIDTH'(~i);
        end
        return img;
    endfunction

    // Configuration-time image; reset deliberately never touches it.
    mem_t mem = init_image();
`else
    mem_t mem;
`endif

    logic wr_in_range;
    logic rd_in_range;
    logic wr_fire;

    assign wr_in_range = ({1'b0, addra} < DEPTH_L);
    assign rd_in_range = ({1'b0, addrb} < DEPTH_L);
    assign wr_fire     = rst_n && ena && wea && wr_in_range;

    // Storage has no reset; rst_n only gates the write strobe.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[addra] <= dina;
        end
    end

    // Nonblocking write above makes a same-edge read return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutb <= '0;
        end else if (enb) begin
            doutb <= rd_in_range ? mem[addrb] : '0;
        end
    end

endmodule

// File: tb/tb_simple_dp_ram.sv
// Randomized and directed bench for simple_dp_ram, checked against an array model.
module tb_simple_dp_ram;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int A  = 4;
    localparam int D2 = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena, wea, enb;
    logic [A-1:0] addra, addrb;
    logic [W-1:0] dina;
    logic [W-1:0] doutb, doutb2;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] model [D];
    bit           known [D];
    logic [W-1:0] exp1, exp2;
    bit           k1, k2;

    always #5 clk = ~clk;

    simple_dp_ram #(.WIDTH(W), .DEPTH(D), .ADDR(A)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb)
    );

    // Shorter instance sharing all inputs: exercises out-of-range addresses.
    simple_dp_ram #(.WIDTH(W), .DEPTH(D2), .ADDR(A)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb2)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs are set at the negedge; apply one edge, update the model, compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            exp1 = '0; k1 = 1'b1;
            exp2 = '0; k2 = 1'b1;
        end else begin
            if (enb) begin
                exp1 = model[addrb];
                k1   = known[addrb];
                if (int'(addrb) >= D2) begin
                    exp2 = '0; k2 = 1'b1;
                end else begin
                    exp2 = model[addrb]; k2 = known[addrb];
                end
            end
            if (ena && wea) begin
                model[addra] = dina;
                known[addra] = 1'b1;
            end
        end
        #1;
        if (k1) check(tag, doutb, exp1);
        if (k2) check({tag, "_small"}, doutb2, exp2);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; wea = 1'b0; enb = 1'b1;
        addra = '0; addrb = '0; dina = '0;
        for (int i = 0; i < D; i++) begin
`ifdef SDP_RAM_INIT_EN
            model[i] = W'(~i);
            known[i] = 1'b1;
`else
            model[i] = 'x;
            known[i] = 1'b0;
`endif
        end
        exp1 = '0; k1 = 1'b1; exp2 = '0; k2 = 1'b1;
        @(negedge clk);

        // Reset held with reads and writes requested: nothing may take effect.
        for (int i = 0; i < 4; i++) begin
            enb = 1'b1; addrb = A'($urandom);
            ena = 1'b1; wea = 1'b1; addra = A'($urandom); dina = W'($urandom);
            step("rst_hold");
        end
        rst_n = 1'b1; ena = 1'b0; wea = 1'b0; enb = 1'b0;
        step("post_rst_idle");

`ifdef SDP_RAM_INIT_EN
        enb = 1'b1;
        for (int i = 0; i < D; i++) begin
            addrb = A'(i);
            step("init_sweep");
        end
`endif

        // Write mem[i] = i, then read back with writes disabled.
        ena = 1'b1; wea = 1'b1; enb = 1'b0;
        for (int i = 0; i < D; i++) begin
            addra = A'(i); dina = W'(i);
            step("wr_hold");
        end
        wea = 1'b0; enb = 1'b1;
        for (int i = 0; i < D; i++) begin
            addrb = A'(i); addra = A'(i); dina = 8'hEE;
            step("wr_rd");
        end

        // Same-address collision returns the old word, new word next cycle.
        for (int i = 0; i < D; i++) begin
            ena = 1'b1; wea = 1'b1; enb = 1'b1;
            addra = A'(i); addrb = A'(i); dina = 8'hC0 ^ W'(i);
            step("collide");
            wea = 1'b0;
            step("collide_reread");
        end

        // ena=0 blocks the write even with wea=1.
        ena = 1'b0; wea = 1'b1; addra = 4'd3; dina = 8'hAA; enb = 1'b0;
        step("ena_gate_wr");
        wea = 1'b0; enb = 1'b1; addrb = 4'd3;
        step("ena_gate_rd");

        // enb=0 freezes doutb while addrb moves.
        enb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addrb = A'($urandom);
            step("enb_hold");
        end

        // Addresses beyond the small instance's depth.
        ena = 1'b1; wea = 1'b1; enb = 1'b0;
        for (int i = D2; i < D; i++) begin
            addra = A'(i); dina = W'($urandom);
            step("oor_wr");
        end
        ena = 1'b0; wea = 1'b0; enb = 1'b1;
        for (int i = D2; i < D; i++) begin
            addrb = A'(i);
            step("oor_rd");
        end

        // Mid-operation reset: async clear, dropped write, contents retained.
        ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 8'h55; enb = 1'b0;
        step("mid_wr");
        ena = 1'b0; wea = 1'b0; enb = 1'b1; addrb = 4'd7;
        step("mid_pre_rst");
        rst_n = 1'b0;
        #1;
        check("async_rst", doutb, 8'h00);
        check("async_rst_small", doutb2, 8'h00);
        exp1 = '0; k1 = 1'b1; exp2 = '0; k2 = 1'b1;
        ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 8'h99;
        step("mid_in_rst");
        step("mid_in_rst");
        rst_n = 1'b1; ena = 1'b0; wea = 1'b0; enb = 1'b0;
        step("mid_post_rst");
        enb = 1'b1; addrb = 4'd7;
        step("mid_rd7");
        check("mid_rd7_value", doutb, 8'h55);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            ena   = $urandom_range(0, 3) != 0;
            wea   = $urandom_range(0, 2) != 0;
            enb   = $urandom_range(0, 3) != 0;
            addra = A'($urandom);
            addrb = ($urandom_range(0, 3) == 0) ? addra : A'($urandom);
            dina  = W'($urandom);
            step("random");
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
